// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder. It serves one read or write at a time from
//            a word RAM, with a configurable number of wait states.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mread_en,
    input  logic [31:0] mread_addr,
    input  logic [1:0]  mread_size,
    input  logic        mwrite_en,
    input  logic [31:0] mwrite_addr,
    input  logic [1:0]  mwrite_size,
    input  logic [31:0] mwrite_data,
    output logic [31:0] rd,
    output logic        stall,
    output logic        resp_valid
);

    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    localparam int         AW         = DEPTH_LOG2 + 2;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic            op_wr_q, op_wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     rd_q, rd_d;

    logic [31:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [3:0]           w_be;
    logic [31:0]          w_lanes;
    logic                 w_access;

    // Upper address bits only select a segment, so they alias onto the RAM.
    logic unused_ok;
    assign unused_ok = ^{mread_addr[31:AW], mwrite_addr[31:AW], mread_addr[1:0]};

    assign w_idx    = addr_q[AW-1:2];
    assign w_access = (state_q == S_BUSY) && (count_q == 4'd0);

    always_comb begin
        w_be    = 4'b1111;
        w_lanes = data_q;
        case (size_q)
            2'd0: begin
                w_be    = 4'b0001 << addr_q[1:0];
                w_lanes = {4{data_q[7:0]}};
            end
            2'd1: begin
                w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{data_q[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = data_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (mwrite_en) begin
                    op_wr_d = 1'b1;
                    addr_d  = mwrite_addr[AW-1:0];
                    size_d  = mwrite_size;
                    data_d  = mwrite_data;
                    count_d = COUNT_LOAD;
                    state_d = S_BUSY;
                end else if (mread_en) begin
                    op_wr_d = 1'b0;
                    addr_d  = mread_addr[AW-1:0];
                    size_d  = mread_size;
                    count_d = COUNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    if (!op_wr_q) begin
                        rd_d = mem[w_idx];
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            data_q  <= 32'd0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    // RAM is never cleared; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && w_access && op_wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_lanes[8*i +: 8];
                end
            end
        end
    end

    assign rd         = rd_q;
    assign stall      = !reset && (((state_q == S_IDLE) && (mread_en || mwrite_en)) ||
                                   (state_q == S_BUSY));
    assign resp_valid = !reset && (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Randomized self-checking bench for dmem_responder (two configs).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DL_A = 12;
    localparam int LAT_A = 2;
    localparam int DL_B = 4;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic [1:0]  size;

    logic        ren_a, wen_a, ren_b, wen_b;
    logic [31:0] rd_a, rd_b;
    logic        stall_a, stall_b, rv_a, rv_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram_m [int];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    assign ren_a = ren & ~sel;
    assign wen_a = wen & ~sel;
    assign ren_b = ren & sel;
    assign wen_b = wen & sel;

    dmem_responder #(.DEPTH_LOG2(DL_A), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .reset(reset),
        .mread_en(ren_a), .mread_addr(addr), .mread_size(size),
        .mwrite_en(wen_a), .mwrite_addr(addr), .mwrite_size(size), .mwrite_data(wdata),
        .rd(rd_a), .stall(stall_a), .resp_valid(rv_a)
    );

    dmem_responder #(.DEPTH_LOG2(DL_B), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .mread_en(ren_b), .mread_addr(addr), .mread_size(size),
        .mwrite_en(wen_b), .mwrite_addr(addr), .mwrite_size(size), .mwrite_data(wdata),
        .rd(rd_b), .stall(stall_b), .resp_valid(rv_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Word key into the model: the index wraps at the configured depth.
    function automatic int key_of(input bit s, input logic [31:0] a);
        int words;
        words = s ? (1 << DL_B) : (1 << DL_A);
        return (s ? 32'h0010_0000 : 0) + int'((a >> 2) % words);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int b;
        r = old;
        case (sz)
            2'd0: begin b = int'(a[1:0]); r[8*b +: 8] = d[7:0]; end
            2'd1: begin b = int'(a[1]);   r[16*b +: 16] = d[15:0]; end
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic do_access(input bit s, input bit w, input bit r, input logic [31:0] a,
                             input logic [1:0] sz, input logic [31:0] d);
        int lat, cyc, stall_cnt, resp_at, k;
        logic [31:0] old;
        lat = s ? LAT_B : LAT_A;
        @(negedge clk);
        sel = s; wen = w; ren = r; addr = a; size = sz; wdata = d;
        #1;
        chk("req_stall", {31'd0, s ? stall_b : stall_a}, 32'd1);
        chk("req_resp", {31'd0, s ? rv_b : rv_a}, 32'd0);
        stall_cnt = 1; resp_at = -1; cyc = 0;
        while (resp_at < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (s ? stall_b : stall_a) stall_cnt++;
            if (s ? rv_b : rv_a) resp_at = cyc;
        end
        chk("resp_cycle", 32'(resp_at), 32'(lat + 1));
        chk("stall_cycles", 32'(stall_cnt), 32'(lat + 1));
        wen = 1'b0; ren = 1'b0;
        k = key_of(s, a);
        if (w) begin
            old = ram_m.exists(k) ? ram_m[k] : 32'd0;
            ram_m[k] = merge(old, a, sz, d);
            chk("rd_hold", s ? rd_b : rd_a, last_rd[s]);
        end else if (ram_m.exists(k)) begin
            chk("rd_data", s ? rd_b : rd_a, ram_m[k]);
            last_rd[s] = ram_m[k];
        end else begin
            last_rd[s] = s ? rd_b : rd_a;
        end
    endtask

    task automatic rand_ops(input bit s, input int n);
        logic [31:0] a;
        logic [1:0]  sz;
        int op, widx;
        for (int i = 0; i < n; i++) begin
            sz = 2'($urandom_range(0, 3));
            if (s) begin
                widx = $urandom_range(0, 15);
                a = ($urandom & 32'hFFFF_FFC0) | 32'(widx * 4);
            end else begin
                widx = $urandom_range(64, 71);
                a = ($urandom & 32'hFFFF_C000) | 32'(widx * 4);
            end
            if (sz == 2'd0)      a[1:0] = 2'($urandom_range(0, 3));
            else if (sz == 2'd1) a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
            op = $urandom_range(0, 7);
            if (op == 0)      do_access(s, 1'b1, 1'b1, a, sz, $urandom);
            else if (op < 4)  do_access(s, 1'b1, 1'b0, a, sz, $urandom);
            else              do_access(s, 1'b0, 1'b1, a, sz, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0;
        addr = 32'd0; wdata = 32'd0; size = 2'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_a", rd_a, 32'd0);
        chk("rst_stall_a", {31'd0, stall_a}, 32'd0);
        chk("rst_resp_a", {31'd0, rv_a}, 32'd0);
        chk("rst_rd_b", rd_b, 32'd0);
        reset = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;

        // Segment bits differ between write and read but hit the same word.
        do_access(1'b0, 1'b1, 1'b0, 32'h8000_0010, 2'd2, 32'hDEAD_BEEF);
        do_access(1'b0, 1'b0, 1'b1, 32'hA000_0010, 2'd2, 32'd0);
        chk("tp_word", rd_a, 32'hDEAD_BEEF);

        do_access(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h1122_3344);
        do_access(1'b0, 1'b1, 1'b0, 32'h11, 2'd0, 32'hFFFF_FF5A);
        do_access(1'b0, 1'b0, 1'b1, 32'h10, 2'd2, 32'd0);
        chk("tp_byte", rd_a, 32'h1122_5A44);

        do_access(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h1122_3344);
        do_access(1'b0, 1'b1, 1'b0, 32'h12, 2'd1, 32'h0000_CAFE);
        do_access(1'b0, 1'b0, 1'b1, 32'h10, 2'd2, 32'd0);
        chk("tp_half_hi", rd_a, 32'hCAFE_3344);
        do_access(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h1122_3344);
        do_access(1'b0, 1'b1, 1'b0, 32'h10, 2'd1, 32'h0000_CAFE);
        do_access(1'b0, 1'b0, 1'b1, 32'h10, 2'd2, 32'd0);
        chk("tp_half_lo", rd_a, 32'h1122_CAFE);

        do_access(1'b0, 1'b1, 1'b1, 32'h20, 2'd2, 32'h0102_0304);
        do_access(1'b0, 1'b0, 1'b1, 32'h20, 2'd2, 32'd0);
        chk("tp_both", rd_a, 32'h0102_0304);

        // Reset lands on the edge where the write would have been performed.
        @(negedge clk);
        sel = 1'b0; wen = 1'b1; addr = 32'h10; size = 2'd2; wdata = 32'h9999_9999;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_stall_rst", {31'd0, stall_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0; wen = 1'b0;
        #1;
        chk("abort_stall", {31'd0, stall_a}, 32'd0);
        chk("abort_resp", {31'd0, rv_a}, 32'd0);
        chk("abort_rd", rd_a, 32'd0);
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        do_access(1'b0, 1'b0, 1'b1, 32'h10, 2'd2, 32'd0);
        chk("abort_old", rd_a, 32'h1122_CAFE);

        do_access(1'b1, 1'b1, 1'b0, 32'h40, 2'd2, 32'h600D_F00D);
        do_access(1'b1, 1'b0, 1'b1, 32'h00, 2'd2, 32'd0);
        chk("tp_wrap", rd_b, 32'h600D_F00D);

        for (int i = 64; i < 72; i++) do_access(1'b0, 1'b1, 1'b0, 32'(i * 4), 2'd2, $urandom);
        rand_ops(1'b0, 60);
        for (int i = 0; i < 16; i++) do_access(1'b1, 1'b1, 1'b0, 32'(i * 4), 2'd2, $urandom);
        rand_ops(1'b1, 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
